// File: rtl/spi_exchange_sequencer_if.sv
// Interface bundle for spi_exchange_sequencer: NITTA/SPI event inputs and buffer-control/status outputs.
interface spi_exchange_sequencer_if #(
  parameter int unsigned BCNT_WIDTH = 6
);
  logic                  signal_cycle;
  logic                  signal_wr;
  logic                  cs;
  logic                  spi_ready;
  logic                  buf_rst;
  logic                  copy_rd;
  logic                  copy_wr;
  logic                  flag_start;
  logic                  flag_stop;
  logic [BCNT_WIDTH-1:0] frame_bytes;
  logic                  busy;
  logic                  err_overrun;
  logic                  err_timeout;

  modport slave (
    input  signal_cycle, signal_wr, cs, spi_ready,
    output buf_rst, copy_rd, copy_wr, flag_start, flag_stop, frame_bytes,
           busy, err_overrun, err_timeout
  );

  modport master (
    output signal_cycle, signal_wr, cs, spi_ready,
    input  buf_rst, copy_rd, copy_wr, flag_start, flag_stop, frame_bytes,
           busy, err_overrun, err_timeout
  );
endinterface

// File: rtl/spi_exchange_sequencer.sv
// Sequences the SPI PU buffer set: frames transactions on cs, counts bytes, copies transfer-in words to the send buffer.
// Optional idle-sclk timeout is enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_exchange_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SPI_DATA_WIDTH = 8,
  parameter int unsigned BUF_SIZE       = 6,
  parameter int unsigned CNT_WIDTH      = 4,
  parameter int unsigned BCNT_WIDTH     = 6
`ifdef SPI_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT      = 1024
`endif
) (
  input logic                     clk,
  input logic                     rst,
  spi_exchange_sequencer_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0]  WORDS_MAX = CNT_WIDTH'(BUF_SIZE);
  localparam logic [BCNT_WIDTH-1:0] BYTES_MAX =
    BCNT_WIDTH'(BUF_SIZE * (DATA_WIDTH / SPI_DATA_WIDTH));

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, COPY} state_t;

  state_t                state, state_d;
  logic [CNT_WIDTH-1:0]  wr_cnt, wr_cnt_d;
  logic [CNT_WIDTH-1:0]  copy_n, copy_n_d;
  logic [CNT_WIDTH-1:0]  copy_idx, copy_idx_d;
  logic [BCNT_WIDTH-1:0] byte_cnt, byte_cnt_d, byte_next;
  logic [BCNT_WIDTH-1:0] frame_bytes, frame_bytes_d;
  logic                  byte_sat;
  logic                  buf_rst;
  logic                  copy_rd, copy_rd_d;
  logic                  copy_wr;
  logic                  flag_start, flag_start_d;
  logic                  flag_stop, flag_stop_d;
  logic                  err_overrun, err_overrun_d;
  logic                  err_timeout;
  logic                  restart, restart_d;
  logic                  hold;
  logic                  timeout_hit;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = (state == ACTIVE) && !bus.cs && !bus.spi_ready &&
                       (idle_cnt == IDLE_W'(TIMEOUT - 1));

  // hold keeps a timed-out master from restarting until it releases cs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt    <= '0;
      hold        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (state != ACTIVE || bus.spi_ready) idle_cnt <= '0;
      else                                   idle_cnt <= idle_cnt + 1'b1;
      if (timeout_hit) begin
        hold        <= 1'b1;
        err_timeout <= 1'b1;
      end else if (bus.cs) begin
        hold <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign hold        = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state;
    wr_cnt_d      = wr_cnt;
    copy_n_d      = copy_n;
    copy_idx_d    = copy_idx;
    byte_cnt_d    = byte_cnt;
    frame_bytes_d = frame_bytes;
    copy_rd_d     = 1'b0;
    flag_start_d  = 1'b0;
    flag_stop_d   = 1'b0;
    err_overrun_d = err_overrun;
    restart_d     = restart;
    byte_sat      = (byte_cnt == BYTES_MAX);
    byte_next     = (bus.spi_ready && !byte_sat) ? byte_cnt + 1'b1 : byte_cnt;

    if (bus.signal_cycle) begin
      wr_cnt_d = '0;
    end else if (bus.signal_wr) begin
      if (wr_cnt == WORDS_MAX) err_overrun_d = 1'b1;
      else                     wr_cnt_d      = wr_cnt + 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (bus.cs) state_d = ARMED;
      end
      ARMED: begin
        if (!bus.cs && !hold) begin
          state_d      = ACTIVE;
          flag_start_d = 1'b1;
          byte_cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (bus.spi_ready && byte_sat) err_overrun_d = 1'b1;
        byte_cnt_d = byte_next;
        if (bus.cs || timeout_hit) begin
          frame_bytes_d = byte_next;
          flag_stop_d   = 1'b1;
          state_d       = COPY;
          copy_n_d      = wr_cnt;
          copy_idx_d    = '0;
          restart_d     = 1'b0;
        end
      end
      COPY: begin
        // a new frame during the copy is remembered and started once the copy drains
        if (!bus.cs && !hold) begin
          err_overrun_d = 1'b1;
          restart_d     = 1'b1;
        end
        if (bus.signal_cycle) begin
          state_d       = ARMED;
          err_overrun_d = 1'b1;
          restart_d     = 1'b0;
        end else if (copy_idx != copy_n) begin
          copy_rd_d  = 1'b1;
          copy_idx_d = copy_idx + 1'b1;
        end else if (restart || (!bus.cs && !hold)) begin
          state_d      = ACTIVE;
          flag_start_d = 1'b1;
          byte_cnt_d   = '0;
          restart_d    = 1'b0;
        end else begin
          state_d = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      buf_rst     <= 1'b1;
      wr_cnt      <= '0;
      copy_n      <= '0;
      copy_idx    <= '0;
      byte_cnt    <= '0;
      frame_bytes <= '0;
      copy_rd     <= 1'b0;
      copy_wr     <= 1'b0;
      flag_start  <= 1'b0;
      flag_stop   <= 1'b0;
      err_overrun <= 1'b0;
      restart     <= 1'b0;
    end else begin
      state       <= state_d;
      buf_rst     <= bus.signal_cycle;
      wr_cnt      <= wr_cnt_d;
      copy_n      <= copy_n_d;
      copy_idx    <= copy_idx_d;
      byte_cnt    <= byte_cnt_d;
      frame_bytes <= frame_bytes_d;
      copy_rd     <= copy_rd_d;
      copy_wr     <= copy_rd;
      flag_start  <= flag_start_d;
      flag_stop   <= flag_stop_d;
      err_overrun <= err_overrun_d;
      restart     <= restart_d;
    end
  end

  assign bus.buf_rst     = buf_rst;
  assign bus.copy_rd     = copy_rd;
  assign bus.copy_wr     = copy_wr;
  assign bus.flag_start  = flag_start;
  assign bus.flag_stop   = flag_stop;
  assign bus.frame_bytes = frame_bytes;
  assign bus.busy        = (state == ACTIVE) || (state == COPY);
  assign bus.err_overrun = err_overrun;
  assign bus.err_timeout = err_timeout;

endmodule

// File: tb/tb_spi_exchange_sequencer.sv
// Directed self-checking bench for spi_exchange_sequencer (BUF_SIZE=6, 4 bytes per word).
module tb_spi_exchange_sequencer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   n_start, n_stop, n_rd, n_wr;
  int   stop_cyc, first_rd, last_rd, first_wr, last_wr;

  spi_exchange_sequencer_if #(.BCNT_WIDTH(6)) bus ();

  spi_exchange_sequencer #(
    .DATA_WIDTH(32),
    .SPI_DATA_WIDTH(8),
    .BUF_SIZE(6),
    .CNT_WIDTH(4),
    .BCNT_WIDTH(6)
`ifdef SPI_SEQ_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.flag_start) n_start++;
    if (bus.flag_stop) begin
      n_stop++;
      stop_cyc = cyc;
    end
    if (bus.copy_rd) begin
      if (n_rd == 0) first_rd = cyc;
      n_rd++;
      last_rd = cyc;
    end
    if (bus.copy_wr) begin
      if (n_wr == 0) first_wr = cyc;
      n_wr++;
      last_wr = cyc;
    end
  endtask

  task automatic clear_stats();
    n_start = 0; n_stop = 0; n_rd = 0; n_wr = 0;
    stop_cyc = -1; first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cs = 1'b1; bus.spi_ready = 1'b0; bus.signal_wr = 1'b0; bus.signal_cycle = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    rst = 1'b1;
    bus.cs = 1'b1; bus.spi_ready = 1'b0; bus.signal_wr = 1'b0; bus.signal_cycle = 1'b0;
    repeat (3) tick();
    flags = {bus.copy_rd, bus.copy_wr, bus.flag_start, bus.flag_stop,
             bus.busy, bus.err_overrun, bus.err_timeout};
    n_cmp++;
    if (bus.buf_rst !== 1'b1) begin
      n_bad++; $display("FAIL reset_buf_rst: got %b expected 1", bus.buf_rst);
    end
    n_cmp++;
    if (flags !== 7'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 0000000", flags);
    end
    n_cmp++;
    if (bus.frame_bytes !== 6'd0) begin
      n_bad++; $display("FAIL reset_frame_bytes: got %0d expected 0", bus.frame_bytes);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.buf_rst !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL post_reset: got buf_rst=%b busy=%b expected 0 0", bus.buf_rst, bus.busy);
    end
    // ARMED must already be reached: cs low now starts a frame
    bus.cs = 1'b0;
    tick();
    n_cmp++;
    if (bus.flag_start !== 1'b1 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL armed_in_1clk: got flag_start=%b busy=%b expected 1 1", bus.flag_start, bus.busy);
    end
    bus.cs = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    clear_stats();
    bus.signal_wr = 1'b1;
    repeat (3) tick();
    bus.signal_wr = 1'b0;
    bus.cs = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      bus.spi_ready = 1'b1; tick();
      bus.spi_ready = 1'b0; tick();
    end
    bus.cs = 1'b1;
    repeat (7) tick();
    n_cmp++;
    if (n_start !== 1 || n_stop !== 1) begin
      n_bad++; $display("FAIL basic_flags: got start=%0d stop=%0d expected 1 1", n_start, n_stop);
    end
    n_cmp++;
    if (bus.frame_bytes !== 6'd12) begin
      n_bad++; $display("FAIL basic_frame_bytes: got %0d expected 12", bus.frame_bytes);
    end
    n_cmp++;
    if (n_rd !== 3 || first_rd !== stop_cyc + 1 || last_rd !== stop_cyc + 3) begin
      n_bad++; $display("FAIL basic_copy_rd: got n=%0d first=%0d last=%0d expected 3 %0d %0d",
                        n_rd, first_rd, last_rd, stop_cyc + 1, stop_cyc + 3);
    end
    n_cmp++;
    if (n_wr !== 3 || first_wr !== stop_cyc + 2 || last_wr !== stop_cyc + 4) begin
      n_bad++; $display("FAIL basic_copy_wr: got n=%0d first=%0d last=%0d expected 3 %0d %0d",
                        n_wr, first_wr, last_wr, stop_cyc + 2, stop_cyc + 4);
    end
    n_cmp++;
    if (bus.err_overrun !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_end: got err=%b busy=%b expected 0 0", bus.err_overrun, bus.busy);
    end
  endtask

  task automatic test_buf_rst();
    bus.signal_cycle = 1'b1;
    tick();
    bus.signal_cycle = 1'b0;
    n_cmp++;
    if (bus.buf_rst !== 1'b1) begin
      n_bad++; $display("FAIL buf_rst_pulse: got %b expected 1", bus.buf_rst);
    end
    tick();
    n_cmp++;
    if (bus.buf_rst !== 1'b0) begin
      n_bad++; $display("FAIL buf_rst_release: got %b expected 0", bus.buf_rst);
    end
  endtask

  task automatic test_zero_copy();
    clear_stats();
    bus.cs = 1'b0;
    tick();
    bus.spi_ready = 1'b1;
    repeat (2) tick();
    bus.signal_cycle = 1'b1;
    tick();
    bus.signal_cycle = 1'b0;
    tick();
    bus.spi_ready = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.err_overrun !== 1'b0) begin
      n_bad++; $display("FAIL cycle_in_active: got busy=%b err=%b expected 1 0", bus.busy, bus.err_overrun);
    end
    bus.cs = 1'b1;
    tick();
    n_cmp++;
    if (bus.flag_stop !== 1'b1 || bus.frame_bytes !== 6'd4 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL zero_stop: got stop=%b bytes=%0d busy=%b expected 1 4 1",
                        bus.flag_stop, bus.frame_bytes, bus.busy);
    end
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL zero_armed: got busy=%b expected 0", bus.busy);
    end
    repeat (2) tick();
    n_cmp++;
    if (n_rd !== 0 || n_wr !== 0) begin
      n_bad++; $display("FAIL zero_no_copy: got rd=%0d wr=%0d expected 0 0", n_rd, n_wr);
    end
  endtask

  task automatic test_abort();
    bus.signal_wr = 1'b1;
    repeat (5) tick();
    bus.signal_wr = 1'b0;
    clear_stats();
    bus.cs = 1'b0;
    tick();
    bus.spi_ready = 1'b1; tick();
    bus.spi_ready = 1'b0;
    bus.cs = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++;
    if (bus.copy_rd !== 1'b1 || bus.err_overrun !== 1'b0) begin
      n_bad++; $display("FAIL abort_pre: got copy_rd=%b err=%b expected 1 0", bus.copy_rd, bus.err_overrun);
    end
    bus.signal_cycle = 1'b1;
    tick();
    bus.signal_cycle = 1'b0;
    n_cmp++;
    if (bus.copy_rd !== 1'b0 || bus.busy !== 1'b0 || bus.err_overrun !== 1'b1) begin
      n_bad++; $display("FAIL abort_post: got copy_rd=%b busy=%b err=%b expected 0 0 1",
                        bus.copy_rd, bus.busy, bus.err_overrun);
    end
    repeat (4) tick();
    n_cmp++;
    if (n_rd !== 2 || n_wr !== 2) begin
      n_bad++; $display("FAIL abort_count: got rd=%0d wr=%0d expected 2 2", n_rd, n_wr);
    end
  endtask

  task automatic test_async_rst();
    bus.signal_wr = 1'b1;
    repeat (2) tick();
    bus.signal_wr = 1'b0;
    bus.cs = 1'b0;
    tick();
    bus.spi_ready = 1'b1; tick();
    bus.spi_ready = 1'b0;
    bus.cs = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.copy_rd !== 1'b1) begin
      n_bad++; $display("FAIL async_pre: got copy_rd=%b expected 1", bus.copy_rd);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.copy_rd !== 1'b0 || bus.buf_rst !== 1'b1 || bus.busy !== 1'b0 ||
        bus.err_overrun !== 1'b0 || bus.frame_bytes !== 6'd0) begin
      n_bad++; $display("FAIL async_rst: got rd=%b buf_rst=%b busy=%b err=%b bytes=%0d expected 0 1 0 0 0",
                        bus.copy_rd, bus.buf_rst, bus.busy, bus.err_overrun, bus.frame_bytes);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_byte_overrun();
    do_reset();
    bus.cs = 1'b0;
    tick();
    bus.spi_ready = 1'b1;
    repeat (24) tick();
    n_cmp++;
    if (bus.err_overrun !== 1'b0) begin
      n_bad++; $display("FAIL bytes_24_no_err: got %b expected 0", bus.err_overrun);
    end
    tick();
    n_cmp++;
    if (bus.err_overrun !== 1'b1) begin
      n_bad++; $display("FAIL bytes_25_err: got %b expected 1", bus.err_overrun);
    end
    bus.spi_ready = 1'b0;
    bus.cs = 1'b1;
    tick();
    n_cmp++;
    if (bus.frame_bytes !== 6'd24) begin
      n_bad++; $display("FAIL bytes_saturate: got %0d expected 24", bus.frame_bytes);
    end
    tick();
  endtask

  task automatic test_cs_during_copy();
    do_reset();
    bus.signal_wr = 1'b1;
    repeat (3) tick();
    bus.signal_wr = 1'b0;
    bus.cs = 1'b0;
    tick();
    bus.spi_ready = 1'b1;
    repeat (2) tick();
    bus.spi_ready = 1'b0;
    clear_stats();
    bus.cs = 1'b1;
    tick();
    tick();
    bus.cs = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (n_start !== 1 || bus.flag_start !== 1'b1 || bus.busy !== 1'b1 || bus.err_overrun !== 1'b1) begin
      n_bad++; $display("FAIL cs_in_copy_restart: got starts=%0d flag_start=%b busy=%b err=%b expected 1 1 1 1",
                        n_start, bus.flag_start, bus.busy, bus.err_overrun);
    end
    n_cmp++;
    if (n_rd !== 3 || n_wr !== 3) begin
      n_bad++; $display("FAIL cs_in_copy_complete: got rd=%0d wr=%0d expected 3 3", n_rd, n_wr);
    end
    bus.cs = 1'b1;
    repeat (3) tick();
  endtask

`ifdef SPI_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bus.cs = 1'b0;
    tick();
    bus.spi_ready = 1'b1; tick();
    bus.spi_ready = 1'b0;
    repeat (15) tick();
    n_cmp++;
    if (bus.err_timeout !== 1'b0) begin
      n_bad++; $display("FAIL timeout_early: got %b expected 0", bus.err_timeout);
    end
    clear_stats();
    tick();
    n_cmp++;
    if (bus.err_timeout !== 1'b1 || bus.flag_stop !== 1'b1 || bus.frame_bytes !== 6'd1) begin
      n_bad++; $display("FAIL timeout_fire: got err=%b stop=%b bytes=%0d expected 1 1 1",
                        bus.err_timeout, bus.flag_stop, bus.frame_bytes);
    end
    repeat (4) tick();
    n_cmp++;
    if (n_start !== 0 || bus.busy !== 1'b0 || bus.err_overrun !== 1'b0) begin
      n_bad++; $display("FAIL timeout_hold: got starts=%0d busy=%b err=%b expected 0 0 0",
                        n_start, bus.busy, bus.err_overrun);
    end
    bus.cs = 1'b1; tick();
    bus.cs = 1'b0; tick();
    n_cmp++;
    if (bus.flag_start !== 1'b1) begin
      n_bad++; $display("FAIL timeout_restart: got %b expected 1", bus.flag_start);
    end
    bus.cs = 1'b1;
    repeat (2) tick();
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.cs = 1'b1; bus.spi_ready = 1'b0; bus.signal_wr = 1'b0; bus.signal_cycle = 1'b0;
    clear_stats();
    test_reset();
    test_basic();
    test_buf_rst();
    test_zero_copy();
    test_abort();
    test_async_rst();
    test_byte_overrun();
    test_cs_during_copy();
`ifdef SPI_SEQ_TIMEOUT_EN
    test_timeout();
`else
    n_cmp++;
    if (bus.err_timeout !== 1'b0) begin
      n_bad++; $display("FAIL timeout_disabled: got %b expected 0", bus.err_timeout);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
